hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V CPU. It sits beside the main decoder and drives that decoder's `NoOp` input. It also drives the PC write enable, the IF/ID write enable, the IF flush, and a global pipeline freeze, covering three cases: load-use hazards, taken branches resolved in ID, and variable-latency data-memory accesses. It additionally keeps saturating stall/flush counters and flags a memory timeout.

## Interface
Parameters:
- `CNT_W`, 32, width of the performance counters.
- `MEM_TIMEOUT`, 64, maximum `WAIT` cycles before `err_o` is set; legal range 1..255.

Ports:
- `clk_i`  in  1  the single clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `ID_rs1_i`  in  5  rs1 of the instruction in ID.
- `ID_rs2_i`  in  5  rs2 of the instruction in ID.
- `ID_branch_taken_i`  in  1  beq in ID resolved taken.
- `EX_MemRead_i`  in  1  the instruction in EX is a load.
- `EX_rd_i`  in  5  rd of the instruction in EX.
- `MEM_MemRead_i`  in  1  load in MEM.
- `MEM_MemWrite_i`  in  1  store in MEM.
- `mem_ack_i`  in  1  data memory has completed the access.
- `mem_req_o`  out  1  data-memory request, held until ack.
- `NoOp_o`  out  1  to the decoder's `NoOp`; inserts a bubble into EX.
- `PCWrite_o`  out  1  PC update enable.
- `IFIDWrite_o`  out  1  IF/ID register enable.
- `IF_flush_o`  out  1  zero the IF/ID register.
- `pipe_stall_o`  out  1  freeze all pipeline registers and the PC.
- `stall_cnt_o`  out  `CNT_W`  bubble plus freeze cycles.
- `flush_cnt_o`  out  `CNT_W`  flush cycles.
- `err_o`  out  1  sticky memory-timeout flag.

## Operation
- **FSM states:** `RUN`, `WAIT`.
  - `RUN`: when `MEM_MemRead_i | MEM_MemWrite_i`:
    - drive `mem_req_o=1` and `pipe_stall_o=1` (Mealy outputs);
    - move to `WAIT` and clear the timeout counter.
  - `WAIT`:
    - drive `mem_req_o=1`;
    - drive `pipe_stall_o = ~mem_ack_i`;
    - on `mem_ack_i`, return to `RUN`. The pipeline advances in that ack cycle.
    - `mem_ack_i` is ignored in `RUN`.
- **Load-use hazard:** evaluated only when `pipe_stall_o=0`. The condition is `EX_MemRead_i && EX_rd_i!=0 && (EX_rd_i==ID_rs1_i || EX_rd_i==ID_rs2_i)`. When true: `NoOp_o=1`, `PCWrite_o=0`, `IFIDWrite_o=0`.
- **Branch flush:** when `ID_branch_taken_i`, there is no load-use hazard, and `pipe_stall_o=0`, drive `IF_flush_o=1`. `PCWrite_o` stays 1.
- **Priority:** freeze > load-use > flush.
  - Under freeze: `NoOp_o=0`, `IF_flush_o=0`, `PCWrite_o=0`, `IFIDWrite_o=0`.
  - A branch coinciding with a load-use hazard is not flushed that cycle; it is re-evaluated after the bubble.
- **Defaults** (no event): `PCWrite_o=1`, `IFIDWrite_o=1`, all other control outputs 0.
- **Counters:**
  - `stall_cnt_o` increments on each cycle where `NoOp_o | pipe_stall_o`.
  - `flush_cnt_o` increments on each `IF_flush_o` cycle.
  - Both saturate at all-ones and never wrap.
- **Timeout:**
  - An 8-bit counter increments each `WAIT` cycle without ack.
  - When it reaches `MEM_TIMEOUT`, `err_o` is set and stays set until reset.
  - The FSM keeps waiting; no forced exit.

## Timing
- All control outputs are combinational from state plus inputs, with zero latency. Registered elements are the state, the counters and `err_o`.
- Minimum memory access cost is 1 freeze cycle: the `RUN` detect cycle. If ack arrives in the first `WAIT` cycle, that cycle is not frozen.
- Back-to-back memory ops: the post-ack instruction in MEM is detected in the next `RUN` cycle and re-stalls.
- Load-use costs exactly 1 bubble cycle.
- **Reset values:**
  - state `RUN`;
  - `stall_cnt_o=0`, `flush_cnt_o=0`, `err_o=0`.
- **While `rst_i=1`:**
  - `mem_req_o=0`, `pipe_stall_o=0`, `NoOp_o=0`, `IF_flush_o=0`;
  - `PCWrite_o=0`, `IFIDWrite_o=0`.
- **Reset mid-`WAIT`:** `mem_req_o` drops asynchronously; the access is abandoned, and a late ack after reset is ignored.

## Structure
- Shared package `cpu_pkg`:
  - FSM state enum `hz_state_t` {`RUN`,`WAIT`};
  - opcode constants `OP_RTYPE` 0110011, `OP_ITYPE` 0010011, `OP_LOAD` 0000011, `OP_STORE` 0100011, `OP_BRANCH` 1100011, shared with the main decoder.
- Sub-module `sat_counter` (params `W`; ports `clk_i`, `rst_i`, `inc_i`, `cnt_o`) is instanced twice for the stall and flush counters.

## Test plan
- **Load-use:** `EX_MemRead_i=1`, `EX_rd_i=5`, `ID_rs2_i=5` for one cycle → that cycle `NoOp_o=1`, `PCWrite_o=0`, `IFIDWrite_o=0`; `stall_cnt_o` goes 0→1. The same stimulus with `EX_rd_i=0` → no bubble.
- **Taken branch:** `ID_branch_taken_i=1` alone → `IF_flush_o=1`, `PCWrite_o=1`, `flush_cnt_o`=1. The same cycle combined with a load-use hazard → `NoOp_o=1`, `IF_flush_o=0`.
- **Memory with delayed ack:** `MEM_MemRead_i=1`, ack 3 cycles after `WAIT` entry → `pipe_stall_o` high for 4 cycles and low on the ack cycle; `mem_req_o` high for 5 cycles; `stall_cnt_o`=4.
- **Freeze priority:** load-use hazard during `WAIT` → `NoOp_o=0` throughout the freeze; the bubble appears in the first unfrozen cycle.
- **Timeout:** `MEM_TIMEOUT=4`, no ack → `err_o` rises in the cycle after the 4th `WAIT` cycle, the FSM stays in `WAIT`, and `err_o` remains set after a later ack.
- **Reset:** assert `rst_i` mid-`WAIT` → `mem_req_o`, `pipe_stall_o` and `err_o` go 0 with no clock edge; after release, state is `RUN` and counters are 0. Saturation check: force `CNT_W=2`, apply 5 stall cycles → `stall_cnt_o`=3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Definitions shared by the hazard controller and the main decoder:
// the sequencing FSM state type and the base RISC-V opcode constants.
package cpu_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hz_state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: the hazard-detect inputs,
// the data-memory handshake and the pipeline control outputs.
interface hazard_ctrl_if;
    logic [4:0] ID_rs1_i;
    logic [4:0] ID_rs2_i;
    logic       ID_branch_taken_i;
    logic       EX_MemRead_i;
    logic [4:0] EX_rd_i;
    logic       MEM_MemRead_i;
    logic       MEM_MemWrite_i;
    logic       mem_ack_i;
    logic       mem_req_o;
    logic       NoOp_o;
    logic       PCWrite_o;
    logic       IFIDWrite_o;
    logic       IF_flush_o;
    logic       pipe_stall_o;

    // Pipeline / memory side: drives the hazard inputs, consumes the controls.
    modport master (
        output ID_rs1_i, ID_rs2_i, ID_branch_taken_i, EX_MemRead_i, EX_rd_i,
               MEM_MemRead_i, MEM_MemWrite_i, mem_ack_i,
        input  mem_req_o, NoOp_o, PCWrite_o, IFIDWrite_o, IF_flush_o, pipe_stall_o
    );

    // Hazard controller side.
    modport slave (
        input  ID_rs1_i, ID_rs2_i, ID_branch_taken_i, EX_MemRead_i, EX_rd_i,
               MEM_MemRead_i, MEM_MemWrite_i, mem_ack_i,
        output mem_req_o, NoOp_o, PCWrite_o, IFIDWrite_o, IF_flush_o, pipe_stall_o
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: load-use bubbles, taken-branch IF flush and a global
// freeze while a variable-latency data-memory access is outstanding.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    hazard_ctrl_if.slave     hz,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o
);

    localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

    hz_state_t  state_q;
    logic [7:0] tmo_q;
    logic [7:0] tmo_inc;
    logic       err_q;

    logic mem_op;
    logic load_use;
    logic freeze;
    logic mem_req;
    logic noop;
    logic flush;
    logic advance;

    assign mem_op   = hz.MEM_MemRead_i | hz.MEM_MemWrite_i;
    assign load_use = hz.EX_MemRead_i && (hz.EX_rd_i != 5'd0) &&
                      ((hz.EX_rd_i == hz.ID_rs1_i) || (hz.EX_rd_i == hz.ID_rs2_i));
    assign tmo_inc  = tmo_q + 8'd1;

    // Everything is gated by rst_i so an abandoned access drops mem_req at once.
    always_comb begin
        mem_req = 1'b0;
        freeze  = 1'b0;
        case (state_q)
            RUN: begin
                mem_req = mem_op;
                freeze  = mem_op;
            end
            WAIT: begin
                mem_req = 1'b1;
                freeze  = ~hz.mem_ack_i;
            end
            default: ;
        endcase
        if (rst_i) begin
            mem_req = 1'b0;
            freeze  = 1'b0;
        end
        noop    = ~rst_i & ~freeze & load_use;
        flush   = ~rst_i & ~freeze & ~load_use & hz.ID_branch_taken_i;
        advance = ~rst_i & ~freeze & ~load_use;
    end

    assign hz.mem_req_o    = mem_req;
    assign hz.pipe_stall_o = freeze;
    assign hz.NoOp_o       = noop;
    assign hz.IF_flush_o   = flush;
    assign hz.PCWrite_o    = advance;
    assign hz.IFIDWrite_o  = advance;

    // The timeout only raises err; the access keeps waiting for its ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            tmo_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_op) begin
                        state_q <= WAIT;
                        tmo_q   <= 8'd0;
                    end
                end
                WAIT: begin
                    if (hz.mem_ack_i) begin
                        state_q <= RUN;
                    end else begin
                        if (tmo_q != 8'hFF)
                            tmo_q <= tmo_inc;
                        if (tmo_inc == TMO_LIMIT)
                            err_q <= 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign err_o = err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (noop | freeze),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for single-cycle hazards plus
// hand-written memory, freeze, timeout, reset and saturation sequences.
module tb_hazard_ctrl;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    hazard_ctrl_if hz ();
    hazard_ctrl_if hzs ();

    logic [31:0] stall_cnt, flush_cnt;
    logic        err;
    logic [1:0]  sat_stall, sat_flush;
    logic        sat_err;

    hazard_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .hz          (hz),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt),
        .err_o       (err)
    );

    // Narrow-counter copy fed with identical stimulus for the saturation check.
    hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_sat (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .hz          (hzs),
        .stall_cnt_o (sat_stall),
        .flush_cnt_o (sat_flush),
        .err_o       (sat_err)
    );

    assign hzs.ID_rs1_i          = hz.ID_rs1_i;
    assign hzs.ID_rs2_i          = hz.ID_rs2_i;
    assign hzs.ID_branch_taken_i = hz.ID_branch_taken_i;
    assign hzs.EX_MemRead_i      = hz.EX_MemRead_i;
    assign hzs.EX_rd_i           = hz.EX_rd_i;
    assign hzs.MEM_MemRead_i     = hz.MEM_MemRead_i;
    assign hzs.MEM_MemWrite_i    = hz.MEM_MemWrite_i;
    assign hzs.mem_ack_i         = hz.mem_ack_i;

    int n_chk  = 0;
    int n_pass = 0;
    int unsigned exp_stall = 0;
    int unsigned exp_flush = 0;

    // ctl bit order: {NoOp, PCWrite, IFIDWrite, IF_flush, pipe_stall, mem_req}
    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic       exmr;
        logic [4:0] exrd;
        logic [5:0] ctl;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [5:0] ctl_now();
        return {hz.NoOp_o, hz.PCWrite_o, hz.IFIDWrite_o, hz.IF_flush_o,
                hz.pipe_stall_o, hz.mem_req_o};
    endfunction

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                          input logic exmr, input logic [4:0] exrd,
                          input logic memr, input logic memw, input logic ack);
        hz.ID_rs1_i          = rs1;
        hz.ID_rs2_i          = rs2;
        hz.ID_branch_taken_i = br;
        hz.EX_MemRead_i      = exmr;
        hz.EX_rd_i           = exrd;
        hz.MEM_MemRead_i     = memr;
        hz.MEM_MemWrite_i    = memw;
        hz.mem_ack_i         = ack;
    endtask

    task automatic tick(input string name);
        @(posedge clk_i);
        #1;
        chk({name, "_stall_cnt"}, stall_cnt, exp_stall);
        chk({name, "_flush_cnt"}, flush_cnt, exp_flush);
    endtask

    // Check controls for the current cycle, advance the counter model, clock.
    task automatic cyc(input string name, input logic [5:0] e);
        #1;
        chk({name, "_ctl"}, 32'(ctl_now()), 32'(e));
        if (e[5] | e[1]) exp_stall++;
        if (e[2]) exp_flush++;
        tick(name);
    endtask

    initial begin
        vecs[0] = '{5'd1,  5'd5, 1'b0, 1'b1, 5'd5,  6'b100000};
        vecs[1] = '{5'd1,  5'd5, 1'b0, 1'b1, 5'd0,  6'b011000};
        vecs[2] = '{5'd2,  5'd3, 1'b1, 1'b0, 5'd0,  6'b011100};
        vecs[3] = '{5'd7,  5'd3, 1'b1, 1'b1, 5'd7,  6'b100000};
        vecs[4] = '{5'd4,  5'd6, 1'b0, 1'b1, 5'd3,  6'b011000};
        vecs[5] = '{5'd1,  5'd5, 1'b0, 1'b0, 5'd5,  6'b011000};
        vecs[6] = '{5'd31, 5'd2, 1'b1, 1'b1, 5'd31, 6'b100000};
        vecs[7] = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  6'b011000};
        vecs[8] = '{5'd0,  5'd0, 1'b1, 1'b1, 5'd0,  6'b011100};

        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_ctl", 32'(ctl_now()), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Single-cycle hazards in RUN.
        for (int i = 0; i < 9; i++) begin
            set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].br, vecs[i].exmr, vecs[i].exrd,
                   1'b0, 1'b0, 1'b0);
            cyc($sformatf("vec%0d", i), vecs[i].ctl);
        end

        // Load with ack 3 cycles after WAIT entry.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc("mem_detect", 6'b000011);
        for (int i = 1; i <= 3; i++)
            cyc($sformatf("mem_wait%0d", i), 6'b000011);
        hz.mem_ack_i = 1'b1;
        cyc("mem_ack", 6'b011001);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("mem_after", 6'b011000);

        // Load-use held across a store freeze; bubble lands on the ack cycle.
        set_in(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
        cyc("frz_detect", 6'b000011);
        cyc("frz_wait1", 6'b000011);
        hz.mem_ack_i = 1'b1;
        cyc("frz_ack", 6'b100001);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("frz_after", 6'b011000);

        // Timeout at 4 WAIT cycles, sticky across a later ack.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc("tmo_detect", 6'b000011);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("tmo_err_w%0d", i), 32'(err), 32'd0);
            cyc($sformatf("tmo_w%0d", i), 6'b000011);
        end
        chk("tmo_err_w5", 32'(err), 32'd1);
        cyc("tmo_w5", 6'b000011);
        hz.mem_ack_i = 1'b1;
        cyc("tmo_ack", 6'b011001);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("tmo_err_sticky", 32'(err), 32'd1);
        cyc("tmo_after", 6'b011000);

        // Reset asserted mid-WAIT, then a late ack.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc("rw_detect", 6'b000011);
        cyc("rw_wait1", 6'b000011);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rw_ctl", 32'(ctl_now()), 32'd0);
        chk("rw_err", 32'(err), 32'd0);
        chk("rw_stall_cnt", stall_cnt, 32'd0);
        exp_stall = 0;
        exp_flush = 0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cyc("rw_late_ack", 6'b011000);
        hz.mem_ack_i = 1'b0;

        // Five bubbles: wide counter reaches 5, 2-bit counter sticks at 3.
        set_in(5'd9, 5'd1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc($sformatf("sat%0d", i), 6'b100000);
        chk("sat_stall_cnt", 32'(sat_stall), 32'd3);
        chk("sat_flush_cnt", 32'(sat_flush), 32'd0);
        chk("sat_err", 32'(sat_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
